leb128_encoder: RTL and testbench

- Streaming LEB128 encoder for immediate operands on the program-load side of the wasm core.
- Takes one 32- or 64-bit integer per transaction, signed or unsigned.
- Emits the canonical minimal-length LEB128 byte sequence, one byte per handshake.
- Output is in the exact format the core's immediate decoder consumes when fetching from ROM. Used by the bytecode loader to build ROM images and by benches to generate stimulus.

---
 rtl/leb128_encoder_if.sv | 26 ++
 rtl/leb128_encoder.sv | 104 ++++++++++
 tb/tb_leb128_encoder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/leb128_encoder_if.sv
// rtl/leb128_encoder_if.sv - word-in / byte-out handshake bundle for the LEB128 encoder
interface leb128_encoder_if #(
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_value;
  logic             in_signed;
  logic             in_is64;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_byte;
  logic             out_last;
  logic [CNT_W-1:0] byte_index;

  // master: word producer / byte consumer; slave: the encoder itself
  modport master (
    output in_valid, in_value, in_signed, in_is64, out_ready,
    input  in_ready, out_valid, out_byte, out_last, byte_index
  );

  modport slave (
    input  in_valid, in_value, in_signed, in_is64, out_ready,
    output in_ready, out_valid, out_byte, out_last, byte_index
  );
endinterface

// File: rtl/leb128_encoder.sv
// rtl/leb128_encoder.sv - streaming canonical LEB128 encoder, one byte per handshake
module leb128_encoder #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  leb128_encoder_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [63:0]      sr;
  logic [63:0]      rest;
  logic             sgn;
  logic             is64;
  logic [CNT_W-1:0] idx;
  logic             capped;
  logic             natural_end;
  logic             done;
  logic [63:0]      operand;

  always_comb begin
    // Arithmetic vs logical shift folded into the fill bit
    rest        = {{7{sgn & sr[63]}}, sr[63:7]};
    capped      = is64 ? (idx == CNT_W'(9)) : (idx == CNT_W'(4));
    if (sgn) begin
      natural_end = ((rest == '0) && !sr[6]) || ((rest == '1) && sr[6]);
    end else begin
      natural_end = (rest == '0);
    end
    done = capped || natural_end;
  end

  always_comb begin
    if (bus.in_is64) begin
      operand = bus.in_value;
    end else begin
      operand = {{32{bus.in_signed & bus.in_value[31]}}, bus.in_value[31:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_byte   = 8'h00;
    bus.out_last   = 1'b0;
    bus.byte_index = idx;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_byte  = {~done, sr[6:0]};
        bus.out_last  = done;
        if (bus.out_ready && done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr   <= '0;
      sgn  <= 1'b0;
      is64 <= 1'b0;
      idx  <= '0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        sr   <= operand;
        sgn  <= bus.in_signed;
        is64 <= bus.in_is64;
        idx  <= '0;
      end
    end else if (bus.out_ready) begin
      if (done) begin
        idx <= '0;
      end else begin
        sr  <= rest;
        idx <= idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_leb128_encoder.sv
// tb/tb_leb128_encoder.sv - table-driven scoreboard bench for leb128_encoder
module tb_leb128_encoder;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  leb128_encoder_if #(.CNT_W(CNT_W)) bus ();

  leb128_encoder #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // bytes holds the expected sequence with byte 0 in the low octet
  typedef struct packed {
    logic [63:0] value;
    logic        sgn;
    logic        is64;
    logic [4:0]  n;
    logic [79:0] bytes;
  } vec_t;

  vec_t        tbl [14];
  logic [12:0] sb_q [$];
  int          checks = 0;
  int          fails  = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_byte: got %0h expected no byte", bus.out_byte);
      end else begin
        check("byte", {bus.byte_index, bus.out_last, bus.out_byte}, sb_q.pop_front());
      end
    end
  end

  task automatic start(input vec_t v, input int npush);
    @(posedge clk);
    #1;
    bus.in_value  = v.value;
    bus.in_signed = v.sgn;
    bus.in_is64   = v.is64;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    check("accept_ready", bus.in_ready, 1);
    for (int i = 0; i < npush; i++) begin
      sb_q.push_back({4'(i), (i == v.n - 1), v.bytes[8*i +: 8]});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_value = {$urandom, $urandom};
  endtask

  task automatic wait_idle(output int cyc);
    bit idle;
    idle = 1'b0;
    cyc  = 0;
    while (!idle && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.in_ready) idle = 1'b1;
    end
    if (!idle) begin
      checks++;
      fails++;
      $display("FAIL idle_timeout: got in_ready 0 expected 1 within 40 cycles");
    end
  endtask

  task automatic encode(input vec_t v);
    int cyc;
    start(v, v.n);
    @(negedge clk);
    check("latency_valid", bus.out_valid, 1);
    wait_idle(cyc);
    check("cycles_to_ready", cyc + 1, v.n + 1);
    check("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    tbl[0]  = '{64'd624485,              1'b0, 1'b1, 5'd3,  80'h26_8E_E5};
    tbl[1]  = '{64'hFFFFFFFF_FFFE1DC0,   1'b1, 1'b0, 5'd3,  80'h78_BB_C0};
    tbl[2]  = '{64'd0,                   1'b1, 1'b0, 5'd1,  80'h00};
    tbl[3]  = '{64'hFFFFFFFF_FFFFFFFF,   1'b1, 1'b0, 5'd1,  80'h7F};
    tbl[4]  = '{64'd64,                  1'b1, 1'b0, 5'd2,  80'h00_C0};
    tbl[5]  = '{64'hFFFFFFFF_FFFFFFC0,   1'b1, 1'b0, 5'd1,  80'h40};
    tbl[6]  = '{64'hDEADBEEF_FFFFFFFF,   1'b0, 1'b0, 5'd5,  80'h0F_FF_FF_FF_FF};
    tbl[7]  = '{64'h80000000_00000000,   1'b1, 1'b1, 5'd10, 80'h7F_80_80_80_80_80_80_80_80_80};
    tbl[8]  = '{64'd127,                 1'b0, 1'b0, 5'd1,  80'h7F};
    tbl[9]  = '{64'd128,                 1'b0, 1'b0, 5'd2,  80'h01_80};
    tbl[10] = '{64'hFFFFFFFF_FFFFFFFF,   1'b0, 1'b1, 5'd10, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF};
    tbl[11] = '{64'h7FFFFFFF_FFFFFFFF,   1'b1, 1'b1, 5'd10, 80'h00_FF_FF_FF_FF_FF_FF_FF_FF_FF};
    tbl[12] = '{64'h12345678_FFFFFF80,   1'b1, 1'b0, 5'd2,  80'h7F_80};
    tbl[13] = '{64'h00000001_00000000,   1'b0, 1'b1, 5'd5,  80'h10_80_80_80_80};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.in_signed = 1'b0;
    bus.in_is64   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", {bus.in_ready, bus.out_valid, bus.out_last, bus.out_byte, bus.byte_index},
          {1'b1, 1'b0, 1'b0, 8'h00, 4'h0});

    for (int k = 0; k < 14; k++) begin
      encode(tbl[k]);
    end

    // Three stalled cycles on E5, with a stray word offered mid-sequence
    bus.out_ready = 1'b0;
    start(tbl[0], tbl[0].n);
    bus.in_valid = 1'b1;
    bus.in_value = 64'h55;
    repeat (3) begin
      @(negedge clk);
      check("stall_hold", {bus.out_valid, bus.byte_index, bus.out_last, bus.out_byte},
            {1'b1, 4'h0, 1'b0, 8'hE5});
      check("stall_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle(cyc);
    check("stall_sb_empty", sb_q.size(), 0);
    repeat (3) begin
      @(negedge clk);
      check("no_stray_accept", bus.out_valid, 0);
    end

    // Abort -123456 right after C0 transfers
    start(tbl[1], 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_state", {bus.in_ready, bus.out_valid, bus.out_last, bus.out_byte, bus.byte_index},
          {1'b1, 1'b0, 1'b0, 8'h00, 4'h0});
    check("abort_sb_empty", sb_q.size(), 0);

    encode(tbl[8]);
    encode(tbl[9]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
